// File: rtl/icdf_lane_arbiter_if.sv
// rtl/icdf_lane_arbiter_if.sv - lane-side and shared-unit-side handshake bundle for icdf_lane_arbiter
interface icdf_lane_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    logic [N-1:0]             req_valid;
    logic [N-1:0]             req_ready;
    logic [N*WIDTH-1:0]       req_u;
    logic [N-1:0]             rsp_valid;
    logic [N-1:0]             rsp_ready;
    logic [N*WIDTH-1:0]       rsp_z;
    logic                     icdf_valid_in;
    logic                     icdf_ready_out;
    logic [WIDTH-1:0]         icdf_u_in;
    logic                     icdf_valid_out;
    logic                     icdf_ready_in;
    logic [WIDTH-1:0]         icdf_z_out;
    logic [$clog2(DEPTH):0]   inflight;

    // The arbiter itself.
    modport slave (
        input  req_valid, req_u, rsp_ready, icdf_ready_out, icdf_valid_out, icdf_z_out,
        output req_ready, rsp_valid, rsp_z, icdf_valid_in, icdf_u_in, icdf_ready_in, inflight
    );

    // Lanes plus shared inverse-CDF unit, seen from outside the arbiter.
    modport master (
        output req_valid, req_u, rsp_ready, icdf_ready_out, icdf_valid_out, icdf_z_out,
        input  req_ready, rsp_valid, rsp_z, icdf_valid_in, icdf_u_in, icdf_ready_in, inflight
    );
endinterface

// File: rtl/icdf_lane_arbiter.sv
// rtl/icdf_lane_arbiter.sv - round-robin sharing of one inverse-CDF pipeline among N lanes
module icdf_lane_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int QFRAC = 16,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    icdf_lane_arbiter_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [WIDTH-1:0] U_ONE = {{(WIDTH-1){1'b0}}, 1'b1} << QFRAC;
    localparam logic [WIDTH-1:0] U_MAX = U_ONE - {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] U_MIN = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW:0]      N_W   = (PW+1)'(N);
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    tag_mem_q [DEPTH];

    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic [PW:0]      grant_sum;
    logic [PW-1:0]    grant;
    logic             found;
    logic [WIDTH-1:0] granted_u;
    logic [WIDTH-1:0] clamped_u;
    logic [PW-1:0]    head;
    logic             empty;
    logic             full;
    logic             issue;
    logic             pop;

    // Rotate requests so bit 0 is the lane at rr_ptr; the first set bit is the winner.
    always_comb begin
        req_dbl   = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
        req_rot   = req_dbl[N-1:0];
        grant     = '0;
        grant_sum = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_rot[k]) begin
                found     = 1'b1;
                grant_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
                if (grant_sum >= N_W) begin
                    grant_sum = grant_sum - N_W;
                end
                grant = grant_sum[PW-1:0];
            end
        end
    end

    always_comb begin
        granted_u = '0;
        for (int k = 0; k < N; k++) begin
            if (grant == PW'(k)) begin
                granted_u = bus.req_u[k*WIDTH +: WIDTH];
            end
        end
    end

    // Keep the uniform strictly inside (0,1) so the inverse CDF never sees +/- infinity.
    always_comb begin
        if (granted_u[WIDTH-1] || (granted_u == '0)) begin
            clamped_u = U_MIN;
        end else if (granted_u >= U_ONE) begin
            clamped_u = U_MAX;
        end else begin
            clamped_u = granted_u;
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign head  = tag_mem_q[rd_ptr_q];

    // Full blocks issue even when a pop is under way, so no rsp_ready -> req_ready path exists.
    assign bus.icdf_valid_in = rst_n && (|bus.req_valid) && !full;
    assign bus.icdf_u_in     = clamped_u;
    assign issue             = bus.icdf_valid_in && bus.icdf_ready_out;
    assign bus.req_ready     = issue ? (N'(1) << grant) : '0;

    assign bus.icdf_ready_in = !empty && bus.rsp_ready[head];
    assign bus.rsp_valid     = (bus.icdf_valid_out && !empty) ? (N'(1) << head) : '0;
    assign bus.rsp_z         = {N{bus.icdf_z_out}};
    assign pop               = bus.icdf_valid_out && bus.icdf_ready_in;
    assign bus.inflight      = count_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (issue) begin
            rr_ptr_d = (grant == PW'(N-1)) ? '0 : grant + PW'(1);
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({issue, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (issue) begin
                tag_mem_q[wr_ptr_q] <= grant;
            end
        end
    end

    // A result with no outstanding tag has no owner; the shared unit broke protocol.
    a_no_orphan_result: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.icdf_valid_out && empty));

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= FULL_CNT);
endmodule

// File: tb/tb_icdf_lane_arbiter.sv
// tb/tb_icdf_lane_arbiter.sv - randomized scoreboard bench for icdf_lane_arbiter
module tb_icdf_lane_arbiter;
    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int QFRAC = 16;
    localparam int DEPTH = 8;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icdf_lane_arbiter_if #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    icdf_lane_arbiter #(.N(N), .WIDTH(WIDTH), .QFRAC(QFRAC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          lane;
        logic [31:0] u;
        int          due;
    } ent_t;

    ent_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          ref_rr = 0;
    int          cyc = 0;
    bit          unit_hold = 1'b0;
    bit          unit_ready = 1'b0;

    bit          e_vin, e_issue, e_ready_in, e_pop;
    int          e_grant;
    logic [31:0] e_u, e_z;
    logic [N-1:0] e_req_ready, e_rsp_valid;

    function automatic logic [31:0] clamp(input logic [31:0] u);
        int s;
        s = $signed(u);
        if (s <= 0) return 32'd1;
        if (s >= (1 << QFRAC)) return (1 << QFRAC) - 1;
        return u;
    endfunction

    function automatic logic [31:0] zfun(input logic [31:0] u);
        return (u * 32'd2654435761) ^ 32'h0F0F_0F0F;
    endfunction

    function automatic logic [31:0] rand_u();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0001_0000;
            2:       return 32'h8000_0000 | 32'($urandom);
            3:       return 32'($urandom_range(1, 65535));
            4:       return 32'($urandom);
            default: return 32'h0001_0000 + 32'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic set_lane_u(input int l, input logic [31:0] v);
        bus.req_u[l*WIDTH +: WIDTH] = v;
    endtask

    // Shared unit: fixed latency, output held until accepted.
    task automatic drive_unit();
        bus.icdf_ready_out = unit_ready;
        if (q.size() > 0 && !unit_hold && q[0].due <= cyc) begin
            bus.icdf_valid_out = 1'b1;
            bus.icdf_z_out     = zfun(q[0].u);
        end else begin
            bus.icdf_valid_out = 1'b0;
            bus.icdf_z_out     = 32'hDEAD_BEEF;
        end
    endtask

    task automatic compute_exp();
        e_grant = 0;
        for (int k = 0; k < N; k++) begin
            int l;
            l = (ref_rr + k) % N;
            if (bus.req_valid[l]) begin
                e_grant = l;
                break;
            end
        end
        e_vin       = rst_n && (bus.req_valid != 0) && (q.size() < DEPTH);
        e_issue     = e_vin && unit_ready;
        e_u         = clamp(bus.req_u[e_grant*WIDTH +: WIDTH]);
        e_req_ready = e_issue ? N'(1 << e_grant) : '0;
        e_rsp_valid = '0;
        e_ready_in  = 1'b0;
        e_z         = 32'h0;
        if (q.size() > 0) begin
            e_ready_in = bus.rsp_ready[q[0].lane];
            if (bus.icdf_valid_out) e_rsp_valid[q[0].lane] = 1'b1;
            e_z = zfun(q[0].u);
        end
        e_pop = bus.icdf_valid_out && e_ready_in;
    endtask

    task automatic tick();
        @(negedge clk);
        drive_unit();
        #1;
        compute_exp();
    endtask

    task automatic advance();
        @(posedge clk);
        if (e_pop) void'(q.pop_front());
        if (e_issue) begin
            q.push_back('{lane: e_grant, u: e_u, due: cyc + LAT});
            ref_rr = (e_grant + 1) % N;
        end
        cyc++;
        #1;
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        q.delete();
        ref_rr    = 0;
        unit_hold = 1'b0;
        drive_unit();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        unit_ready    = 1'b1;
        for (int l = 0; l < N; l++) set_lane_u(l, 32'h0000_4000 + 32'(l));
        drive_unit();
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (bus.icdf_valid_in !== 1'b0) begin miscompares++; $display("FAIL reset_valid_in: got %b want 0", bus.icdf_valid_in); end
        vectors++;
        if (bus.inflight !== '0) begin miscompares++; $display("FAIL reset_inflight: got %0d want 0", bus.inflight); end
        vectors++;
        if (bus.rsp_valid !== '0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        vectors++;
        if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL reset_first_grant: got %b want 0001", bus.req_ready); end
        advance();
        bus.req_valid = '0;
        tick();
        vectors++;
        if (bus.inflight !== 4'd1) begin miscompares++; $display("FAIL reset_first_inflight: got %0d want 1", bus.inflight); end
        advance();
    endtask

    task automatic test_round_robin();
        hard_reset();
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        unit_ready    = 1'b1;
        for (int i = 0; i < 24; i++) begin
            for (int l = 0; l < N; l++) set_lane_u(l, rand_u());
            tick();
            vectors++;
            if (bus.req_ready !== N'(1 << (i % N))) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b want %b", i, bus.req_ready, N'(1 << (i % N))); end
            vectors++;
            if (bus.icdf_u_in !== e_u) begin miscompares++; $display("FAIL rr_u[%0d]: got %h want %h", i, bus.icdf_u_in, e_u); end
            vectors++;
            if (bus.rsp_valid !== ((i >= LAT) ? N'(1 << ((i - LAT) % N)) : N'(0))) begin
                miscompares++; $display("FAIL rr_rsp_valid[%0d]: got %b want lane %0d after %0d cycles", i, bus.rsp_valid, (i - LAT) % N, LAT);
            end
            if (e_rsp_valid != 0) begin
                vectors++;
                if (bus.rsp_z[q[0].lane*WIDTH +: WIDTH] !== e_z) begin miscompares++; $display("FAIL rr_rsp_z[%0d]: got %h want %h", i, bus.rsp_z[q[0].lane*WIDTH +: WIDTH], e_z); end
            end
            advance();
        end
    endtask

    task automatic test_full();
        hard_reset();
        unit_hold     = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        unit_ready    = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            advance();
        end
        tick();
        vectors++;
        if (bus.inflight !== 4'(DEPTH)) begin miscompares++; $display("FAIL full_inflight: got %0d want %0d", bus.inflight, DEPTH); end
        vectors++;
        if (bus.req_ready !== '0) begin miscompares++; $display("FAIL full_req_ready: got %b want 0", bus.req_ready); end
        vectors++;
        if (bus.icdf_valid_in !== 1'b0) begin miscompares++; $display("FAIL full_valid_in: got %b want 0", bus.icdf_valid_in); end
        advance();
        unit_hold = 1'b0;
        tick();
        vectors++;
        if (bus.icdf_valid_in !== 1'b0) begin miscompares++; $display("FAIL full_pop_blocks_issue: got %b want 0", bus.icdf_valid_in); end
        vectors++;
        if (bus.icdf_ready_in !== 1'b1) begin miscompares++; $display("FAIL full_pop_ready_in: got %b want 1", bus.icdf_ready_in); end
        advance();
        unit_hold = 1'b1;
        tick();
        vectors++;
        if (bus.inflight !== 4'(DEPTH - 1)) begin miscompares++; $display("FAIL full_after_pop: got %0d want %0d", bus.inflight, DEPTH - 1); end
        vectors++;
        if (bus.req_ready !== e_req_ready || e_req_ready == 0) begin miscompares++; $display("FAIL full_resume: got %b want %b", bus.req_ready, e_req_ready); end
        advance();
        tick();
        vectors++;
        if (bus.inflight !== 4'(DEPTH)) begin miscompares++; $display("FAIL full_refill: got %0d want %0d", bus.inflight, DEPTH); end
        advance();
    endtask

    task automatic test_clamp();
        logic [31:0] tin  [8];
        logic [31:0] tout [8];
        tin[0] = 32'h0000_0000; tout[0] = 32'h0000_0001;
        tin[1] = 32'h0001_0000; tout[1] = 32'h0000_FFFF;
        tin[2] = 32'hFFFF_8000; tout[2] = 32'h0000_0001;
        tin[3] = 32'h0000_8000; tout[3] = 32'h0000_8000;
        tin[4] = 32'h0000_FFFF; tout[4] = 32'h0000_FFFF;
        tin[5] = 32'h7FFF_FFFF; tout[5] = 32'h0000_FFFF;
        tin[6] = 32'h8000_0000; tout[6] = 32'h0000_0001;
        tin[7] = 32'h0000_0001; tout[7] = 32'h0000_0001;
        hard_reset();
        unit_ready    = 1'b0;
        bus.req_valid = 4'b0010;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] v, want;
            if (i < 8) begin v = tin[i]; want = tout[i]; end
            else begin v = rand_u(); want = clamp(v); end
            set_lane_u(1, v);
            tick();
            vectors++;
            if (bus.icdf_u_in !== want) begin miscompares++; $display("FAIL clamp[%0d] u=%h: got %h want %h", i, v, bus.icdf_u_in, want); end
            advance();
        end
    endtask

    task automatic test_hol();
        logic [31:0] u2;
        hard_reset();
        u2 = 32'h0000_3C00;
        set_lane_u(2, u2);
        set_lane_u(0, 32'h0000_1234);
        bus.rsp_ready = 4'b1011;
        unit_ready    = 1'b1;
        bus.req_valid = 4'b0100;
        tick(); advance();
        bus.req_valid = 4'b0001;
        tick(); advance();
        bus.req_valid = '0;
        tick(); advance();
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (bus.icdf_ready_in !== 1'b0) begin miscompares++; $display("FAIL hol_ready_in[%0d]: got %b want 0", i, bus.icdf_ready_in); end
            vectors++;
            if (bus.rsp_valid !== 4'b0100) begin miscompares++; $display("FAIL hol_rsp_valid[%0d]: got %b want 0100", i, bus.rsp_valid); end
            vectors++;
            if (bus.rsp_z[2*WIDTH +: WIDTH] !== zfun(u2)) begin miscompares++; $display("FAIL hol_rsp_z[%0d]: got %h want %h", i, bus.rsp_z[2*WIDTH +: WIDTH], zfun(u2)); end
            vectors++;
            if (bus.inflight !== 4'd2) begin miscompares++; $display("FAIL hol_inflight[%0d]: got %0d want 2", i, bus.inflight); end
            advance();
        end
        bus.rsp_ready = '1;
        tick();
        vectors++;
        if (bus.icdf_ready_in !== 1'b1) begin miscompares++; $display("FAIL hol_release: got %b want 1", bus.icdf_ready_in); end
        advance();
        tick();
        vectors++;
        if (bus.inflight !== 4'd1) begin miscompares++; $display("FAIL hol_after_pop: got %0d want 1", bus.inflight); end
        vectors++;
        if (bus.rsp_valid !== 4'b0001) begin miscompares++; $display("FAIL hol_next_head: got %b want 0001", bus.rsp_valid); end
        advance();
    endtask

    task automatic test_reset_mid();
        hard_reset();
        unit_hold     = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = '0;
        unit_ready    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); advance();
        end
        bus.req_valid = '0;
        unit_hold     = 1'b0;
        tick();
        vectors++;
        if (bus.inflight !== 4'd5 || bus.rsp_valid !== 4'b0001) begin
            miscompares++; $display("FAIL midrst_before: got inflight %0d rsp_valid %b want 5 0001", bus.inflight, bus.rsp_valid);
        end
        bus.req_valid = '1;
        #2;
        rst_n = 1'b0;
        q.delete();
        ref_rr = 0;
        drive_unit();
        #1;
        vectors++;
        if (bus.inflight !== '0) begin miscompares++; $display("FAIL midrst_inflight: got %0d want 0", bus.inflight); end
        vectors++;
        if (bus.rsp_valid !== '0) begin miscompares++; $display("FAIL midrst_rsp_valid: got %b want 0", bus.rsp_valid); end
        vectors++;
        if (bus.icdf_valid_in !== 1'b0) begin miscompares++; $display("FAIL midrst_valid_in: got %b want 0", bus.icdf_valid_in); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        vectors++;
        if (bus.req_ready !== 4'b0001 || bus.inflight !== '0) begin
            miscompares++; $display("FAIL midrst_restart: got req_ready %b inflight %0d want 0001 0", bus.req_ready, bus.inflight);
        end
        advance();
    endtask

    task automatic test_random();
        hard_reset();
        for (int i = 0; i < 600; i++) begin
            bus.req_valid = N'($urandom);
            bus.rsp_ready = N'($urandom) | N'($urandom);
            unit_ready    = ($urandom_range(0, 3) != 0);
            for (int l = 0; l < N; l++) set_lane_u(l, rand_u());
            tick();
            vectors++;
            if (bus.icdf_valid_in !== e_vin) begin miscompares++; $display("FAIL rnd_valid_in[%0d]: got %b want %b", i, bus.icdf_valid_in, e_vin); end
            vectors++;
            if (bus.req_ready !== e_req_ready) begin miscompares++; $display("FAIL rnd_req_ready[%0d]: got %b want %b", i, bus.req_ready, e_req_ready); end
            if (e_vin) begin
                vectors++;
                if (bus.icdf_u_in !== e_u) begin miscompares++; $display("FAIL rnd_u[%0d]: got %h want %h", i, bus.icdf_u_in, e_u); end
            end
            vectors++;
            if (bus.rsp_valid !== e_rsp_valid) begin miscompares++; $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", i, bus.rsp_valid, e_rsp_valid); end
            vectors++;
            if (bus.icdf_ready_in !== e_ready_in) begin miscompares++; $display("FAIL rnd_ready_in[%0d]: got %b want %b", i, bus.icdf_ready_in, e_ready_in); end
            vectors++;
            if (int'(bus.inflight) !== q.size()) begin miscompares++; $display("FAIL rnd_inflight[%0d]: got %0d want %0d", i, bus.inflight, q.size()); end
            if (e_rsp_valid != 0) begin
                vectors++;
                if (bus.rsp_z[q[0].lane*WIDTH +: WIDTH] !== e_z) begin miscompares++; $display("FAIL rnd_rsp_z[%0d]: got %h want %h", i, bus.rsp_z[q[0].lane*WIDTH +: WIDTH], e_z); end
            end
            advance();
        end
    endtask

    initial begin
        bus.req_valid      = '0;
        bus.req_u          = '0;
        bus.rsp_ready      = '0;
        bus.icdf_ready_out = 1'b0;
        bus.icdf_valid_out = 1'b0;
        bus.icdf_z_out     = '0;
        test_reset();
        test_round_robin();
        test_full();
        test_clamp();
        test_hol();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
